cla_addsub_pipe: RTL and testbench
==================================

Name: cla_addsub_pipe

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor for the datapath ALU.
- Operand width is split into SEG-bit segments; one segment is resolved per cycle and carry is registered between stages, so clock period is independent of WIDTH.
- Adds add-with-carry / subtract-with-borrow modes, status flags, and a valid/ready handshake with backpressure.
- Sits between the register-file read stage and ALU writeback.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of SEG
SEG, 4, bits resolved per pipeline stage; multiple of 4, each stage built from SEG/4 4-bit lookahead groups
STAGES, WIDTH/SEG, derived, not overridable; equals latency in cycles

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  block accepts beat this cycle
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_op  in  2  00 ADD, 01 SUB, 10 ADC, 11 SBC
in_c  in  1  carry in for ADC/SBC (SBC: 1 = no borrow)
in_sat  in  1  request signed saturation (see Optional Feature)
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_r  out  WIDTH  result
out_co  out  1  carry out (SUB/SBC: 1 = no borrow)
out_ovf  out  1  signed overflow
out_z  out  1  out_r == 0
out_n  out  1  out_r[WIDTH-1]
out_sat  out  1  result was clamped

Behaviour:
- Reset: on a clk edge with rst_n=0, all stage valid bits, out_valid, out_r and all flags clear to 0.
- in_ready is 0 while rst_n=0.
- Operand setup: b_eff = in_op[0] ? ~in_b : in_b.
- Carry in (cin) by op: ADD 0, SUB 1, ADC in_c, SBC in_c.
- Stage k (0..STAGES-1) adds segment k of a and b_eff with the carry registered by stage k-1 (stage 0 uses cin).
- Unprocessed operand segments travel with the beat (staircase alignment); completed result segments accumulate.
- Latency: exactly STAGES cycles from accepted beat to out_valid when unstalled. Throughput: 1 beat/cycle.
- Global advance: adv = !out_valid || out_ready. in_ready = adv (combinational). Every stage register loads only when adv=1; when adv=0 the whole pipe holds.
- Beat accepted iff in_valid && in_ready. Bubbles propagate as valid=0 stages.
- out_r, flags and out_valid are stable while out_valid=1 and out_ready=0.
- Flags are computed in the final stage from the full result:
  - out_co = carry out of the top segment.
  - out_ovf = (a_msb == b_eff_msb) && (r_msb != a_msb).
  - out_z and out_n are taken from the post-saturation result.
- Wrap-around: ADD 0xFFFF+0x0001 gives r=0x0000, co=1, z=1. No exception signalled.
- Simultaneous out_ready and in_valid with a full pipe: drain and accept in the same cycle, no bubble.
- Reset mid-operation: all in-flight beats are dropped, none are emitted after reset releases.
- in_c and in_sat are sampled only on acceptance.

Optional Feature:
Macro CLA_SAT_EN.
- Defined: when the accepted beat had in_sat=1 and out_ovf=1, out_r clamps to 0x7FF..F if a_msb=0, else 0x80..0; out_sat=1. out_ovf and out_co still report the unclamped operation.
- Undefined: in_sat is ignored, out_sat is tied to 0, and there is no clamp logic.

Test Plan (WIDTH=16, SEG=4, STAGES=4):
1. ADD 0x1234+0x1111, out_ready=1 -> out_valid exactly 4 cycles after acceptance, r=0x2345, co=0, ovf=0, z=0, n=0.
2. SUB 0x0005-0x0007 -> r=0xFFFE, co=0, n=1. SBC 0x0000-0x0000 with in_c=0 -> r=0xFFFF, co=0.
3. Back-to-back 8 ADC beats (a=i, b=i, in_c=1) with out_ready held 0 for cycles 6-9 -> in_ready low exactly while stalled. Results 2i+1 in order, none lost or duplicated.
4. ADD 0x7FFF+0x0001 -> r=0x8000, ovf=1. With CLA_SAT_EN and in_sat=1 -> r=0x7FFF, out_sat=1. Without the macro -> r=0x8000, out_sat=0.
5. ADD 0xFFFF+0x0001 -> r=0x0000, co=1, z=1.
6. Reset asserted 2 cycles after accepting 3 beats -> next cycle out_valid=0, all flags 0. No stale result emerges in the 8 cycles after rst_n returns high.

Source files
------------

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead add/subtract: one SEG-bit segment per stage, carry registered between stages.
// Optional signed saturation is built only when CLA_SAT_EN is defined.
module cla_addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_c,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_r,
    output logic             out_co,
    output logic             out_ovf,
    output logic             out_z,
    output logic             out_n,
    output logic             out_sat
);
    localparam int STAGES = WIDTH / SEG;
    localparam int GROUPS = SEG / 4;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] r;
        logic             c;
`ifdef CLA_SAT_EN
        logic             sat;
`endif
    } beat_t;

    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
        logic [3:0] g, p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | ((&p) & ci);
        return {c[4], p ^ c[3:0]};
    endfunction

    beat_t            pipe_q [STAGES];
    beat_t            pipe_d [STAGES+1];
    logic [STAGES:0]  vld_q;
    logic [WIDTH-1:0] r_q, r_d;
    logic             co_q, ovf_q, z_q, n_q, sat_q;
    logic             ovf_d, sat_d;
    logic             adv;

    assign adv      = !vld_q[STAGES] || out_ready;
    assign in_ready = adv && rst_n;

    // pipe_d[0] is the incoming beat; pipe_d[k+1] is pipe_q[k] with segment k resolved.
    always_comb begin
        logic cy;
        pipe_d[0].a = in_a;
        pipe_d[0].b = in_op[0] ? ~in_b : in_b;
        pipe_d[0].r = '0;
        pipe_d[0].c = in_op[1] ? in_c : in_op[0];
`ifdef CLA_SAT_EN
        pipe_d[0].sat = in_sat;
`endif
        for (int k = 0; k < STAGES; k++) begin
            pipe_d[k+1] = pipe_q[k];
            cy = pipe_q[k].c;
            for (int g = 0; g < GROUPS; g++) begin
                {cy, pipe_d[k+1].r[k*SEG+g*4 +: 4]} =
                    cla4(pipe_q[k].a[k*SEG+g*4 +: 4], pipe_q[k].b[k*SEG+g*4 +: 4], cy);
            end
            pipe_d[k+1].c = cy;
        end
    end

    // Flags come from the fully resolved beat; co/ovf describe the unclamped sum.
    always_comb begin
        ovf_d = (pipe_d[STAGES].a[WIDTH-1] == pipe_d[STAGES].b[WIDTH-1]) &&
                (pipe_d[STAGES].r[WIDTH-1] != pipe_d[STAGES].a[WIDTH-1]);
        r_d   = pipe_d[STAGES].r;
        sat_d = 1'b0;
`ifdef CLA_SAT_EN
        if (pipe_d[STAGES].sat && ovf_d) begin
            r_d   = pipe_d[STAGES].a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            sat_d = 1'b1;
        end
`endif
    end

`ifndef CLA_SAT_EN
    logic unused_sat;
    assign unused_sat = in_sat;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < STAGES; k++) pipe_q[k] <= '0;
            r_q   <= '0;
            co_q  <= 1'b0;
            ovf_q <= 1'b0;
            z_q   <= 1'b0;
            n_q   <= 1'b0;
            sat_q <= 1'b0;
        end else if (adv) begin
            vld_q     <= {vld_q[STAGES-1:0], in_valid};
            pipe_q[0] <= pipe_d[0];
            for (int k = 1; k < STAGES; k++) pipe_q[k] <= pipe_d[k];
            if (vld_q[STAGES-1]) begin
                r_q   <= r_d;
                co_q  <= pipe_d[STAGES].c;
                ovf_q <= ovf_d;
                z_q   <= (r_d == '0);
                n_q   <= r_d[WIDTH-1];
                sat_q <= sat_d;
            end
        end
    end

    assign out_valid = vld_q[STAGES];
    assign out_r     = r_q;
    assign out_co    = co_q;
    assign out_ovf   = ovf_q;
    assign out_z     = z_q;
    assign out_n     = n_q;
    assign out_sat   = sat_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Bench for cla_addsub_pipe: arithmetic reference model + scoreboard queue, directed literals, random traffic.
module tb_cla_addsub_pipe;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [1:0]   in_op = 2'd0;
    logic         in_c = 1'b0;
    logic         in_sat = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_r;
    logic         out_co, out_ovf, out_z, out_n, out_sat;

    cla_addsub_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_c(in_c), .in_sat(in_sat),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_co(out_co), .out_ovf(out_ovf),
        .out_z(out_z), .out_n(out_n), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic         co, ovf, z, n, sat;
    } exp_t;

    int           checks = 0;
    int           errors = 0;
    exp_t         exp_q[$];
    logic [W-1:0] got_q[$];
    bit           collect = 1'b0;
    exp_t         cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [1:0] op, input logic c, input logic sat);
        exp_t         e;
        logic [W-1:0] be;
        logic [W:0]   sum;
        logic         ci;
        be    = op[0] ? ~b : b;
        ci    = (op == 2'd0) ? 1'b0 : (op == 2'd1) ? 1'b1 : c;
        sum   = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ci};
        e.r   = sum[W-1:0];
        e.co  = sum[W];
        e.ovf = (a[W-1] == be[W-1]) && (e.r[W-1] != a[W-1]);
        e.sat = 1'b0;
`ifdef CLA_SAT_EN
        if (sat && e.ovf) begin
            e.r   = a[W-1] ? 16'h8000 : 16'h7FFF;
            e.sat = 1'b1;
        end
`else
        if (sat) e.sat = 1'b0;
`endif
        e.z = (e.r == '0);
        e.n = e.r[W-1];
        return e;
    endfunction

    // Scoreboard fill: every accepted beat, in order; reset flushes it.
    always @(posedge clk) begin
        if (!rst_n) exp_q.delete();
        else if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_op, in_c, in_sat));
    end

    // Output checker on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready_rule", in_ready, !out_valid || out_ready);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", out_valid, 1'b0);
                end else begin
                    cur = exp_q[0];
                    chk("r",   out_r,   cur.r);
                    chk("co",  out_co,  cur.co);
                    chk("ovf", out_ovf, cur.ovf);
                    chk("z",   out_z,   cur.z);
                    chk("n",   out_n,   cur.n);
                    chk("sat", out_sat, cur.sat);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        if (collect) got_q.push_back(out_r);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] op, input logic c, input logic sat,
                           input logic [W-1:0] er, input logic eco, input logic eovf,
                           input logic ez, input logic en, input logic esat);
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a = a; in_b = b; in_op = op; in_c = c; in_sat = sat;
        step();
        in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        chk({name, "_latency"}, lat, 4);
        if (lat != 0) begin
            chk({name, "_r"},   out_r,   er);
            chk({name, "_co"},  out_co,  eco);
            chk({name, "_ovf"}, out_ovf, eovf);
            chk({name, "_z"},   out_z,   ez);
            chk({name, "_n"},   out_n,   en);
            chk({name, "_sat"}, out_sat, esat);
        end
        step();
    endtask

    task automatic chk_cleared(input string name);
        chk({name, "_valid"}, out_valid, 1'b0);
        chk({name, "_r"},     out_r,     '0);
        chk({name, "_flags"}, {out_co, out_ovf, out_z, out_n, out_sat}, 5'b0);
        chk({name, "_in_ready"}, in_ready, 1'b0);
    endtask

    initial begin
        int  idx;
        bit  acc;

        // Reset
        rst_n = 1'b0;
        step();
        chk_cleared("reset");
        step();
        rst_n = 1'b1;
        step();

        // Directed literals
        run_one("add_basic", 16'h1234, 16'h1111, 2'd0, 1'b0, 1'b0, 16'h2345, 0, 0, 0, 0, 0);
        run_one("sub_neg",   16'h0005, 16'h0007, 2'd1, 1'b0, 1'b0, 16'hFFFE, 0, 0, 0, 1, 0);
        run_one("sbc_zero",  16'h0000, 16'h0000, 2'd3, 1'b0, 1'b0, 16'hFFFF, 0, 0, 0, 1, 0);
        run_one("add_wrap",  16'hFFFF, 16'h0001, 2'd0, 1'b0, 1'b0, 16'h0000, 1, 0, 1, 0, 0);
        run_one("add_ovf",   16'h7FFF, 16'h0001, 2'd0, 1'b0, 1'b0, 16'h8000, 0, 1, 0, 1, 0);
`ifdef CLA_SAT_EN
        run_one("sat_pos",   16'h7FFF, 16'h0001, 2'd0, 1'b0, 1'b1, 16'h7FFF, 0, 1, 0, 0, 1);
        run_one("sat_neg",   16'h8000, 16'h8000, 2'd0, 1'b0, 1'b1, 16'h8000, 1, 1, 0, 1, 1);
`else
        run_one("sat_pos",   16'h7FFF, 16'h0001, 2'd0, 1'b0, 1'b1, 16'h8000, 0, 1, 0, 1, 0);
        run_one("sat_neg",   16'h8000, 16'h8000, 2'd0, 1'b0, 1'b1, 16'h0000, 1, 1, 1, 0, 0);
`endif

        // Back-to-back ADC beats with a consumer stall in cycles 6-9
        got_q.delete();
        collect = 1'b1;
        idx = 0;
        for (int t = 0; t < 40; t++) begin
            in_valid  = (idx < 8);
            in_op     = 2'd2;
            in_a      = W'(idx);
            in_b      = W'(idx);
            in_c      = 1'b1;
            in_sat    = 1'b0;
            out_ready = !(t >= 6 && t <= 9);
            @(negedge clk);
            acc = in_valid && in_ready;
            chk("stall_in_ready", in_ready, !(t >= 6 && t <= 9));
            step();
            if (acc) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        collect   = 1'b0;
        chk("adc_count", got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++)
            chk("adc_order", got_q[i], 2 * i + 1);

        // Random traffic against the model
        for (int t = 0; t < 400; t++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_op     = 2'($urandom_range(0, 3));
            in_c      = 1'($urandom);
            in_sat    = 1'($urandom);
            case ($urandom_range(0, 5))
                0:       in_a = 16'h7FFF;
                1:       in_a = 16'h8000;
                2:       in_a = 16'hFFFF;
                default: in_a = 16'($urandom);
            endcase
            in_b = ($urandom_range(0, 4) == 0) ? 16'h0001 : 16'($urandom);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) step();
        chk("drain_empty", exp_q.size(), 0);

        // Reset with beats in flight
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_op    = 2'd0;
            in_a     = 16'h0100 + 16'(i);
            in_b     = 16'h0011;
            step();
        end
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        chk_cleared("mid_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("post_reset_quiet", out_valid, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
